// File: rtl/tlcd_bus_monitor_if.sv
// Text LCD bus signal bundle: the controller/font loader drives it as master,
// the shadow monitor observes it as slave.
interface tlcd_bus_monitor_if;
  logic       TLCD_E;
  logic       TLCD_RS;
  logic       TLCD_RW;
  logic [7:0] TLCD_DATA;

  modport master (output TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA);
  modport slave  (input  TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA);
endinterface

// File: rtl/tlcd_bus_monitor.sv
// Passive HD44780-style bus responder: decodes commands/data writes and keeps a
// 2x16 register shadow of the visible DDRAM with a registered read port.
module tlcd_bus_monitor #(
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter int         LINE_LEN   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  tlcd_bus_monitor_if.slave     bus,
  input  logic [4:0]            rd_addr,
  output logic [7:0]            rd_data,
  output logic                  wr_strobe,
  output logic [4:0]            wr_pos,
  output logic [7:0]            wr_char,
  output logic                  wr_onscreen,
  output logic                  cg_strobe,
  output logic                  cmd_strobe,
  output logic [7:0]            cmd_code,
  output logic [6:0]            ac,
  output logic                  cg_mode,
  output logic                  entry_inc,
  output logic                  display_on,
  output logic                  proto_err
);
  localparam int CELLS = 2 * LINE_LEN;

  logic       e_q, e_dly_q, armed_q;
  logic       rs_q, rw_q;
  logic [7:0] data_q;
  logic       cap_rs_q, cap_rw_q;
  logic [7:0] cap_data_q;

  logic [7:0] shadow_q [CELLS];
  logic [7:0] rd_data_q;

  logic [6:0] ac_q, ac_d;
  logic       cg_mode_q, cg_mode_d;
  logic       entry_inc_q, entry_inc_d;
  logic       display_on_q, display_on_d;
  logic [7:0] cmd_code_q, cmd_code_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [4:0] wr_pos_q, wr_pos_d;
  logic [7:0] wr_char_q, wr_char_d;
  logic       wr_onscreen_q, wr_onscreen_d;
  logic       cg_strobe_q, cg_strobe_d;
  logic       cmd_strobe_q, cmd_strobe_d;
  logic       proto_err_q, proto_err_d;
  logic       clear_all, cell_we;
  logic       accept;

  function automatic logic ddram_valid(input logic [6:0] a);
    return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
  endfunction

  function automatic logic [6:0] ddram_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else     r = (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
    return r;
  endfunction

  // armed_q keeps an E that was already high out of reset from being taken as a transaction.
  assign accept = armed_q & e_dly_q & ~e_q;

  always_comb begin
    ac_d          = ac_q;
    cg_mode_d     = cg_mode_q;
    entry_inc_d   = entry_inc_q;
    display_on_d  = display_on_q;
    cmd_code_d    = cmd_code_q;
    wr_pos_d      = wr_pos_q;
    wr_char_d     = wr_char_q;
    wr_onscreen_d = wr_onscreen_q;
    wr_strobe_d   = 1'b0;
    cg_strobe_d   = 1'b0;
    cmd_strobe_d  = 1'b0;
    proto_err_d   = 1'b0;
    clear_all     = 1'b0;
    cell_we       = 1'b0;
    if (accept) begin
      if (cap_rw_q) begin
        proto_err_d = 1'b1;
      end else if (!cap_rs_q) begin
        cmd_strobe_d = 1'b1;
        cmd_code_d   = cap_data_q;
        casez (cap_data_q)
          8'b1???????: begin
            cg_mode_d = 1'b0;
            if (ddram_valid(cap_data_q[6:0])) begin
              ac_d = cap_data_q[6:0];
            end else begin
              ac_d        = 7'h00;
              proto_err_d = 1'b1;
            end
          end
          8'b01??????: begin
            ac_d      = {1'b0, cap_data_q[5:0]};
            cg_mode_d = 1'b1;
          end
          8'b001?????, 8'b0001????: ;
          8'b00001???: display_on_d = cap_data_q[2];
          8'b000001??: entry_inc_d  = cap_data_q[1];
          8'b0000001?: begin
            ac_d      = 7'h00;
            cg_mode_d = 1'b0;
          end
          8'b00000001: begin
            clear_all   = 1'b1;
            ac_d        = 7'h00;
            cg_mode_d   = 1'b0;
            entry_inc_d = 1'b1;
          end
          default: ;
        endcase
      end else if (cg_mode_q) begin
        cg_strobe_d = 1'b1;
        ac_d        = {1'b0, entry_inc_q ? ac_q[5:0] + 6'd1 : ac_q[5:0] - 6'd1};
      end else begin
        wr_strobe_d = 1'b1;
        wr_char_d   = cap_data_q;
        // Visible cells are 0x00-0x0F (upper line) and 0x40-0x4F (lower line).
        if (ac_q[6:4] == 3'b000 || ac_q[6:4] == 3'b100) begin
          wr_pos_d      = {ac_q[6], ac_q[3:0]};
          wr_onscreen_d = 1'b1;
          cell_we       = 1'b1;
        end else begin
          wr_pos_d      = 5'd0;
          wr_onscreen_d = 1'b0;
        end
        ac_d = ddram_step(ac_q, entry_inc_q);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e_q           <= 1'b1;
      e_dly_q       <= 1'b0;
      armed_q       <= 1'b0;
      rs_q          <= 1'b0;
      rw_q          <= 1'b0;
      data_q        <= 8'h00;
      cap_rs_q      <= 1'b0;
      cap_rw_q      <= 1'b0;
      cap_data_q    <= 8'h00;
      ac_q          <= 7'h00;
      cg_mode_q     <= 1'b0;
      entry_inc_q   <= 1'b1;
      display_on_q  <= 1'b0;
      cmd_code_q    <= 8'h00;
      wr_strobe_q   <= 1'b0;
      wr_pos_q      <= 5'd0;
      wr_char_q     <= 8'h00;
      wr_onscreen_q <= 1'b0;
      cg_strobe_q   <= 1'b0;
      cmd_strobe_q  <= 1'b0;
      proto_err_q   <= 1'b0;
      rd_data_q     <= BLANK_CHAR;
      for (int i = 0; i < CELLS; i++) shadow_q[i] <= BLANK_CHAR;
    end else begin
      e_q     <= bus.TLCD_E;
      rs_q    <= bus.TLCD_RS;
      rw_q    <= bus.TLCD_RW;
      data_q  <= bus.TLCD_DATA;
      e_dly_q <= e_q;
      armed_q <= armed_q | ~e_q;
      if (e_q) begin
        cap_rs_q   <= rs_q;
        cap_rw_q   <= rw_q;
        cap_data_q <= data_q;
      end
      ac_q          <= ac_d;
      cg_mode_q     <= cg_mode_d;
      entry_inc_q   <= entry_inc_d;
      display_on_q  <= display_on_d;
      cmd_code_q    <= cmd_code_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_pos_q      <= wr_pos_d;
      wr_char_q     <= wr_char_d;
      wr_onscreen_q <= wr_onscreen_d;
      cg_strobe_q   <= cg_strobe_d;
      cmd_strobe_q  <= cmd_strobe_d;
      proto_err_q   <= proto_err_d;
      rd_data_q     <= shadow_q[rd_addr];
      if (clear_all) begin
        for (int i = 0; i < CELLS; i++) shadow_q[i] <= BLANK_CHAR;
      end else if (cell_we) begin
        shadow_q[wr_pos_d] <= cap_data_q;
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_pos      = wr_pos_q;
  assign wr_char     = wr_char_q;
  assign wr_onscreen = wr_onscreen_q;
  assign cg_strobe   = cg_strobe_q;
  assign cmd_strobe  = cmd_strobe_q;
  assign cmd_code    = cmd_code_q;
  assign ac          = ac_q;
  assign cg_mode     = cg_mode_q;
  assign entry_inc   = entry_inc_q;
  assign display_on  = display_on_q;
  assign proto_err   = proto_err_q;
endmodule

// File: doc/tlcd_bus_monitor.md
Name: tlcd_bus_monitor

Overview:
- Passive responder on the text LCD bus (TLCD_E/RS/RW/DATA). It is the receiving end of what the text LCD controller and font loader drive.
- Decodes HD44780-style commands and data writes, and keeps a 2x16 shadow of displayed characters (DDRAM) in registers.
- Exposes the shadow through a registered read port and per-write strobes. Used for on-chip display mirroring and self-check of the game screen.

Parameters:
- BLANK_CHAR, 8'h20, value loaded into every shadow cell on reset and on Clear Display.
- LINE_LEN, 16, visible characters per line. Fixed at 16; other values unsupported.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- TLCD_E  in  1  LCD enable strobe, synchronous to CLK
- TLCD_RS  in  1  0 = command, 1 = data
- TLCD_RW  in  1  0 = write, 1 = read
- TLCD_DATA  in  8  LCD data bus
- rd_addr  in  5  shadow read index: 0-15 upper line, 16-31 lower line
- rd_data  out  8  shadow[rd_addr], registered
- wr_strobe  out  1  one-cycle pulse per accepted DDRAM data write
- wr_pos  out  5  shadow index written; valid with wr_strobe
- wr_char  out  8  character written; valid with wr_strobe
- wr_onscreen  out  1  1 if the write landed in a visible cell; valid with wr_strobe
- cg_strobe  out  1  one-cycle pulse per CGRAM data write
- cmd_strobe  out  1  one-cycle pulse per command (RS=0, RW=0)
- cmd_code  out  8  last command byte, held
- ac  out  7  current DDRAM/CGRAM address counter
- cg_mode  out  1  1 when the last address command was Set CGRAM Address
- entry_inc  out  1  I/D flag from Entry Mode Set
- display_on  out  1  D bit from Display Control
- proto_err  out  1  one-cycle pulse on a read cycle (RW=1) or an invalid DDRAM address

Behaviour:
- Input stage: TLCD_* are registered once. A transaction is accepted on the falling edge of the registered E (registered E 1 -> 0).
- The transaction uses RS/RW/DATA as registered in the last cycle E was high. Strobe outputs assert the cycle after the falling edge is detected.
- Reset values:
  - all 32 shadow cells = BLANK_CHAR
  - ac = 0, cg_mode = 0, entry_inc = 1, display_on = 0, cmd_code = 0
  - all strobes = 0, proto_err = 0, rd_data = BLANK_CHAR, wr_pos = 0, wr_char = 0, wr_onscreen = 0
- Reset mid-transaction discards it. An E that is high when RST deasserts is ignored until it has been seen low once.
- RW=1 transaction: no state change; proto_err pulses.
- Command decode (RS=0, RW=0), priority from MSB; cmd_strobe pulses and cmd_code latches on every command:
  - 1xxxxxxx Set DDRAM Address: ac = DATA[6:0], cg_mode = 0. Valid ranges are 0x00-0x27 and 0x40-0x67. Any other value sets ac = 0 and pulses proto_err.
  - 01xxxxxx Set CGRAM Address: ac = {1'b0, DATA[5:0]}, cg_mode = 1.
  - 001xxxxx Function Set: no effect beyond cmd_strobe.
  - 0001xxxx Cursor/Display Shift: no effect beyond cmd_strobe.
  - 00001DCB Display Control: display_on = D.
  - 000001Ix Entry Mode Set: entry_inc = I.
  - 0000001x Return Home: ac = 0, cg_mode = 0, shadow unchanged.
  - 00000001 Clear Display: all 32 cells = BLANK_CHAR in one cycle; ac = 0, cg_mode = 0, entry_inc = 1.
  - 00000000: no effect beyond cmd_strobe.
- Data write (RS=1, RW=0):
  - If cg_mode = 1: ac[5:0] advances by +/-1 per entry_inc, wrapping mod 64; cg_strobe pulses; shadow unchanged.
  - Else: wr_strobe pulses and wr_char = DATA.
    - Visible cells: ac 0x00-0x0F map to pos = ac; ac 0x40-0x4F map to pos = 16 + ac[3:0]. These write the shadow, wr_onscreen = 1.
    - Off-screen addresses (0x10-0x27, 0x50-0x67) do not write the shadow; wr_onscreen = 0, wr_pos = 0.
    - ac then advances.
- DDRAM ac advance:
  - increment: +1, with 0x27 -> 0x40 and 0x67 -> 0x00
  - decrement: -1, with 0x40 -> 0x27 and 0x00 -> 0x67
- Read port: rd_data = shadow[rd_addr] one cycle after rd_addr is presented.
  - A same-cycle write to that cell returns the old value (read-before-write); the new value appears the following cycle.
  - rd_addr is 5 bits, so every value is in range.
- Back-to-back transactions are accepted every 2 CLK cycles minimum (E high 1 cycle, low 1 cycle). Bus timing slower than that is fully supported.

Test Plan:
- Reset, then read rd_addr 0..31 -> every rd_data = 8'h20; ac = 0; entry_inc = 1; display_on = 0.
- Cmd 0x80, then data "AB" -> wr_strobe twice with wr_pos 0,1 and wr_char 8'h41,8'h42; shadow[0..1] = "AB"; ac = 0x02.
- Cmd 0xCF, then data 8'h04, then data 8'h58 -> first write pos 31, wr_onscreen = 1; ac = 0x50; second write wr_onscreen = 0, shadow[31] stays 8'h04.
- Cmd 0x04 (decrement), cmd 0xC0, data 8'h03 -> shadow[16] = 8'h03, ac = 0x27; cmd 0xA7 then data 8'h31 with entry_inc = 1 (after cmd 0x06) -> ac = 0x40.
- Cmd 0x40, 8 data bytes -> 8 cg_strobe pulses, ac = 0x08, shadow unchanged; then cmd 0x01 -> all cells 8'h20, ac = 0, cg_mode = 0.
- Transaction with RW=1 -> proto_err pulse, no other change; cmd 0xB0 -> proto_err pulse, ac = 0; RST asserted while E high -> no write after release.
